bus_master_dp_seq: RTL and testbench

- Parametrised bus-master datapath with a transaction sequencer.
- Holds an outgoing-data register bank, an address register bank and an incoming-data register bank, each NREG deep.
- A single start pulse runs one complete single-beat bus transaction (read or write) with a slave using a req/ack handshake, with an optional timeout.
- Sits between the host register interface and the shared slave bus, one instance per master.

---
 rtl/bus_master_dp_seq.sv | 138 +++++++++++++
 tb/tb_bus_master_dp_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_dp_seq.sv
// Bus-master datapath with a single-beat transaction sequencer.
//
// Holds three NREG-deep register banks: out-data (obank), address (abank) and
// in-data (ibank). A start pulse in IDLE snapshots the selected address and
// (for writes) the selected out-data word onto the slave bus. It then raises
// bus_req and waits for bus_ack, or aborts after TIMEOUT wait cycles.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   wr_en/wr_sel/wr_data     host write port, out-data bank
//   aw_en/aw_sel/aw_data     host write port, address bank
//   start, op_rw             launch (IDLE only); 1 = write to slave, 0 = read
//   sr, srA, dr              out-data source, address source, in-data dest
//   rd_sel, rd_data          combinational host read of the in-data bank
//   bus_dout, Abus, bus_din  slave data out, address, data in
//   bus_req, bus_we, bus_ack request, write qualifier, slave completion
//   busy, done, err          in flight; completion pulse; timeout pulse
module bus_master_dp_seq #(
    parameter int unsigned DW      = 32,
    parameter int unsigned AW      = 16,
    parameter int unsigned NREG    = 4,
    parameter int unsigned TIMEOUT = 15,
    localparam int unsigned IW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_sel,
    input  logic [DW-1:0] wr_data,
    input  logic          aw_en,
    input  logic [IW-1:0] aw_sel,
    input  logic [AW-1:0] aw_data,
    input  logic          start,
    input  logic          op_rw,
    input  logic [IW-1:0] sr,
    input  logic [IW-1:0] srA,
    input  logic [IW-1:0] dr,
    input  logic [IW-1:0] rd_sel,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] bus_dout,
    output logic [AW-1:0] Abus,
    input  logic [DW-1:0] bus_din,
    output logic          bus_req,
    output logic          bus_we,
    input  logic          bus_ack,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Timer value on the edge that aborts (only meaningful when TIMEOUT != 0).
    localparam logic [7:0] TLast = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [7:0]      timer_q;
    logic [IW-1:0]   dr_q;
    logic [DW-1:0]   obank [NREG];
    logic [AW-1:0]   abank [NREG];
    logic [DW-1:0]   ibank [NREG];

    logic launch, complete, abort;

    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Ack takes priority over a coincident timeout.
                if (bus_ack) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end else if (TIMEOUT != 0 && timer_q == TLast) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            timer_q  <= '0;
            dr_q     <= '0;
            bus_dout <= '0;
            Abus     <= '0;
            bus_req  <= 1'b0;
            bus_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                obank[i] <= '0;
                abank[i] <= '0;
                ibank[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done    <= complete;
            err     <= abort;

            if (wr_en) obank[wr_sel] <= wr_data;
            if (aw_en) abank[aw_sel] <= aw_data;

            if (launch) begin
                // Snapshot reads the pre-edge bank contents.
                Abus <= abank[srA];
                if (op_rw) bus_dout <= obank[sr];
                bus_we  <= op_rw;
                dr_q    <= dr;
                bus_req <= 1'b1;
                busy    <= 1'b1;
                timer_q <= '0;
            end else if (complete || abort) begin
                if (complete && !bus_we) ibank[dr_q] <= bus_din;
                bus_req <= 1'b0;
                bus_we  <= 1'b0;
                busy    <= 1'b0;
            end else if (state_q == StWait) begin
                timer_q <= timer_q + 8'd1;
            end
        end
    end

    assign rd_data = ibank[rd_sel];

endmodule

// File: tb/tb_bus_master_dp_seq.sv
module tb_bus_master_dp_seq;

    localparam int unsigned DW      = 32;
    localparam int unsigned AW      = 16;
    localparam int unsigned NREG    = 4;
    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned IW      = 2;

    logic          clk, rst;
    logic          wr_en, aw_en, start, op_rw, bus_ack;
    logic [IW-1:0] wr_sel, aw_sel, sr, srA, dr, rd_sel;
    logic [DW-1:0] wr_data, bus_din;
    logic [AW-1:0] aw_data;
    logic [DW-1:0] rd_data, bus_dout;
    logic [AW-1:0] Abus;
    logic          bus_req, bus_we, busy, done, err;

    bus_master_dp_seq #(
        .DW(DW), .AW(AW), .NREG(NREG), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .aw_en(aw_en), .aw_sel(aw_sel), .aw_data(aw_data),
        .start(start), .op_rw(op_rw), .sr(sr), .srA(srA), .dr(dr),
        .rd_sel(rd_sel), .rd_data(rd_data),
        .bus_dout(bus_dout), .Abus(Abus), .bus_din(bus_din),
        .bus_req(bus_req), .bus_we(bus_we), .bus_ack(bus_ack),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level reference model.
    logic [DW-1:0] m_obank [NREG];
    logic [AW-1:0] m_abank [NREG];
    logic [DW-1:0] m_ibank [NREG];
    logic          m_busy, m_rw, m_done, m_err;
    logic [IW-1:0] m_dr;
    int            m_waited;
    logic [DW-1:0] m_dout;
    logic [AW-1:0] m_addr;
    int            n_done_seen, n_err_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_obank[i] = '0; m_abank[i] = '0; m_ibank[i] = '0;
        end
        m_busy = 0; m_rw = 0; m_done = 0; m_err = 0; m_dr = '0;
        m_waited = 0; m_dout = '0; m_addr = '0;
    endtask

    // Apply one clock edge's worth of rules to the model.
    task automatic model_edge();
        m_done = 0;
        m_err  = 0;
        if (!m_busy) begin
            if (start) begin
                m_addr = m_abank[srA];
                if (op_rw) m_dout = m_obank[sr];
                m_rw = op_rw; m_dr = dr; m_busy = 1; m_waited = 0;
            end
        end else begin
            m_waited++;
            if (bus_ack) begin
                if (!m_rw) m_ibank[m_dr] = bus_din;
                m_busy = 0; m_done = 1;
            end else if (TIMEOUT != 0 && m_waited == int'(TIMEOUT)) begin
                m_busy = 0; m_err = 1;
            end
        end
        if (wr_en) m_obank[wr_sel] = wr_data;
        if (aw_en) m_abank[aw_sel] = aw_data;
    endtask

    task automatic check_all();
        check("bus_req",  32'(bus_req),  32'(m_busy));
        check("bus_we",   32'(bus_we),   32'(m_busy & m_rw));
        check("busy",     32'(busy),     32'(m_busy));
        check("done",     32'(done),     32'(m_done));
        check("err",      32'(err),      32'(m_err));
        check("bus_dout", bus_dout,      m_dout);
        check("Abus",     32'(Abus),     32'(m_addr));
        check("rd_data",  rd_data,       m_ibank[rd_sel]);
        check("done_err_excl", 32'(done & err), 32'd0);
        if (done) n_done_seen++;
        if (err)  n_err_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic quiet();
        wr_en = 0; aw_en = 0; start = 0; bus_ack = 0;
    endtask

    initial begin
        int pcts [4];
        int t_err;
        pcts = '{50, 20, 5, 0};
        n_done_seen = 0; n_err_seen = 0;
        rst = 0; quiet();
        op_rw = 0; wr_sel = '0; aw_sel = '0; sr = '0; srA = '0; dr = '0; rd_sel = '0;
        wr_data = '0; aw_data = '0; bus_din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1;

        // Write transaction, ack on 3rd wait cycle.
        wr_en = 1; wr_sel = 2; wr_data = 32'hDEADBEEF;
        aw_en = 1; aw_sel = 1; aw_data = 16'h1234;
        tick();
        quiet(); start = 1; op_rw = 1; sr = 2; srA = 1;
        tick();
        start = 0;
        tick();
        check("wr_abus", 32'(Abus), 32'h1234);
        check("wr_dout", bus_dout, 32'hDEADBEEF);
        check("wr_we", 32'(bus_we), 32'd1);
        tick();
        bus_ack = 1;
        tick();
        check("wr_done", 32'(done), 32'd1);
        bus_ack = 0;
        tick();

        // Read transaction, ack on 1st wait cycle.
        aw_en = 1; aw_sel = 0; aw_data = 16'h00F0;
        tick();
        quiet(); start = 1; op_rw = 0; srA = 0; dr = 3;
        tick();
        start = 0; bus_ack = 1; bus_din = 32'hCAFEF00D;
        tick();
        check("rd_done", 32'(done), 32'd1);
        bus_ack = 0; rd_sel = 3;
        tick();
        check("rd_data3", rd_data, 32'hCAFEF00D);
        rd_sel = 1;
        tick();
        check("rd_data1", rd_data, 32'd0);

        // Timeout, then ack on the final wait cycle.
        t_err = n_err_seen;
        start = 1; op_rw = 0; dr = 0;
        tick();
        start = 0;
        repeat (16) tick();
        check("timeout_err_count", 32'(n_err_seen - t_err), 32'd1);
        start = 1;
        tick();
        start = 0;
        repeat (14) tick();
        bus_ack = 1; bus_din = 32'h5555AAAA;
        tick();
        check("late_ack_done", 32'(done), 32'd1);
        check("late_ack_noerr", 32'(err), 32'd0);
        bus_ack = 0;
        tick();

        // Back-to-back with start held high and changing sources.
        start = 1; op_rw = 1; sr = 2; srA = 1; bus_ack = 1;
        repeat (6) begin
            tick();
            sr = sr + 1; srA = srA + 1;
        end
        quiet();
        tick();

        // Randomized phases with decreasing ack probability.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 600; c++) begin
                wr_en   = ($urandom_range(99) < 30);
                wr_sel  = IW'($urandom);
                wr_data = $urandom;
                aw_en   = ($urandom_range(99) < 30);
                aw_sel  = IW'($urandom);
                aw_data = AW'($urandom);
                start   = ($urandom_range(99) < 40);
                op_rw   = 1'($urandom);
                sr      = IW'($urandom);
                srA     = IW'($urandom);
                dr      = IW'($urandom);
                rd_sel  = IW'($urandom);
                bus_din = $urandom;
                bus_ack = ($urandom_range(99) < pcts[ph]);
                tick();
            end
        end
        quiet();

        // Asynchronous reset in the middle of a wait.
        start = 1; op_rw = 0; dr = 2;
        tick();
        start = 0;
        tick();
        #2 rst = 0;
        #1;
        model_reset();
        check("arst_req",  32'(bus_req), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_dout", bus_dout, 32'd0);
        check("arst_abus", 32'(Abus), 32'd0);
        check("arst_rd",   rd_data, 32'd0);
        @(negedge clk);
        rst = 1;
        check_all();
        aw_en = 1; aw_sel = 3; aw_data = 16'hBEEF;
        tick();
        quiet(); start = 1; op_rw = 0; srA = 3; dr = 2;
        tick();
        start = 0; bus_ack = 1; bus_din = 32'h0BADF00D;
        tick();
        bus_ack = 0; rd_sel = 2;
        tick();
        check("post_rst_rd", rd_data, 32'h0BADF00D);
        check("post_rst_abus", 32'(Abus), 32'hBEEF);
        check("saw_done", 32'(n_done_seen > 0), 32'd1);
        check("saw_err",  32'(n_err_seen > 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
